// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared line geometry and drain-state encodings for the DCache
//               write-back path.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int LINE_WORDS = 8;
    localparam int LINE_BITS  = 256;
    localparam int OFFSET_W   = 5;

    // Line-granular address: byte offset within the 32-byte line dropped
    typedef logic [31:OFFSET_W] line_addr_t;

    // Drain FSM state encoding
    typedef logic [1:0] drain_state_t;
    localparam drain_state_t c_st_idle = 2'd0;
    localparam drain_state_t c_st_addr = 2'd1;
    localparam drain_state_t c_st_data = 2'd2;
    localparam drain_state_t c_st_resp = 2'd3;

endpackage
`default_nettype wire

// File: rtl/line_wr_drain_fsm.sv
`default_nettype none
// ============================================================================
// Module      : line_wr_drain_fsm
// Description : Drains the head line of the write buffer as one address
//               phase, WORDS data beats and a completion response.
// Revision    : 1.0 - initial release
// ============================================================================
module line_wr_drain_fsm #(
    parameter int ADDR_W = 32,
    parameter int WORDS  = cache_pkg::LINE_WORDS
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_head_valid,
    input  logic [ADDR_W-1:cache_pkg::OFFSET_W]  i_head_addr,
    input  logic [32*WORDS-1:0]                  i_head_data,
    input  logic                                 i_awready,
    input  logic                                 i_wready,
    input  logic                                 i_bvalid,
    output logic                                 o_awvalid,
    output logic [ADDR_W-1:0]                    o_awaddr,
    output logic                                 o_wvalid,
    output logic [31:0]                          o_wdata,
    output logic                                 o_wlast,
    output logic                                 o_retire,
    output logic                                 o_idle
);
    import cache_pkg::*;

    localparam int                  c_beat_w    = $clog2(WORDS);
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(WORDS - 1);
    localparam logic [c_beat_w-1:0] c_beat_one  = c_beat_w'(1);

    drain_state_t        r_state;
    logic [c_beat_w-1:0] r_beat;
    logic                w_last_beat;

    assign w_last_beat = (r_beat == c_last_beat);

    // Sequence the head entry through address, data beats and response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_beat  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (i_head_valid) r_state <= c_st_addr;
                end
                c_st_addr: begin
                    if (i_awready) begin
                        r_state <= c_st_data;
                        r_beat  <= '0;
                    end
                end
                c_st_data: begin
                    if (i_wready) begin
                        if (w_last_beat) begin
                            r_state <= c_st_resp;
                            r_beat  <= '0;
                        end else begin
                            r_beat  <= r_beat + c_beat_one;
                        end
                    end
                end
                c_st_resp: begin
                    if (i_bvalid) r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Channel outputs are state-gated so the payload reads zero when not offered
    always_comb begin
        o_awvalid = (r_state == c_st_addr);
        o_wvalid  = (r_state == c_st_data);
        o_awaddr  = '0;
        o_wdata   = '0;
        o_wlast   = 1'b0;
        if (r_state == c_st_addr) begin
            o_awaddr = {i_head_addr, {OFFSET_W{1'b0}}};
        end
        if (r_state == c_st_data) begin
            o_wdata = i_head_data[32*int'(r_beat) +: 32];
            o_wlast = w_last_beat;
        end
        o_retire  = (r_state == c_st_resp) && i_bvalid;
        o_idle    = (r_state == c_st_idle);
    end

endmodule
`default_nettype wire

// File: rtl/line_wr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_wr_buffer
// Description : Dirty-line write-back FIFO between the DCache write port and
//               the cache-to-AXI bridge write channel, with refill conflict
//               detection against every buffered line.
// Revision    : 1.0 - initial release
// ============================================================================
module line_wr_buffer #(
    parameter int DEPTH      = 2,
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    wr_req,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    output logic                    wr_rdy,
    input  logic [ADDR_W-1:0]       rd_chk_addr,
    output logic                    rd_conflict,
    output logic                    empty,
    output logic                    out_awvalid,
    output logic [ADDR_W-1:0]       out_awaddr,
    input  logic                    out_awready,
    output logic                    out_wvalid,
    output logic [31:0]             out_wdata,
    output logic                    out_wlast,
    input  logic                    out_wready,
    input  logic                    out_bvalid
);
    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam int                 c_off_w   = cache_pkg::OFFSET_W;
    localparam logic [c_ptr_w:0]   c_ptr_one = (c_ptr_w + 1)'(1);

    logic [c_ptr_w:0]             r_wr_ptr;
    logic [c_ptr_w:0]             r_rd_ptr;
    logic [DEPTH-1:0]             r_valid;
    logic [ADDR_W-1:c_off_w]      r_addr [DEPTH];
    logic [32*LINE_WORDS-1:0]     r_data [DEPTH];

    logic [c_ptr_w-1:0]           w_wr_idx;
    logic [c_ptr_w-1:0]           w_rd_idx;
    logic                         w_full;
    logic                         w_push;
    logic                         w_retire;
    logic                         w_fsm_idle;
    logic [DEPTH-1:0]             w_hit;
    logic                         w_unused_lsb;

    assign w_wr_idx = r_wr_ptr[c_ptr_w-1:0];
    assign w_rd_idx = r_rd_ptr[c_ptr_w-1:0];
    assign w_full   = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) && (w_wr_idx == w_rd_idx);
    assign wr_rdy   = !w_full;
    assign w_push   = wr_req && !w_full;

    // Byte offsets inside a line carry no information for this buffer
    assign w_unused_lsb = ^{wr_addr[c_off_w-1:0], rd_chk_addr[c_off_w-1:0]};

    // Pointers and valid bits; enqueue and retire may land in the same cycle
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_valid[w_wr_idx] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + c_ptr_one;
            end
            if (w_retire) begin
                r_valid[w_rd_idx] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Line payload; only meaningful while the matching valid bit is set
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_addr[w_wr_idx] <= wr_addr[ADDR_W-1:c_off_w];
            r_data[w_wr_idx] <= wr_data;
        end
    end

    // Refill hazard: compare the pending refill line against every valid entry
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
            assign w_hit[g] = r_valid[g] && (r_addr[g] == rd_chk_addr[ADDR_W-1:c_off_w]);
        end
    endgenerate

    assign rd_conflict = |w_hit;
    assign empty       = !(|r_valid) && w_fsm_idle;

    line_wr_drain_fsm #(
        .ADDR_W (ADDR_W),
        .WORDS  (LINE_WORDS)
    ) u_drain (
        .clk          (aclk),
        .rst_n        (aresetn),
        .i_head_valid (r_valid[w_rd_idx]),
        .i_head_addr  (r_addr[w_rd_idx]),
        .i_head_data  (r_data[w_rd_idx]),
        .i_awready    (out_awready),
        .i_wready     (out_wready),
        .i_bvalid     (out_bvalid),
        .o_awvalid    (out_awvalid),
        .o_awaddr     (out_awaddr),
        .o_wvalid     (out_wvalid),
        .o_wdata      (out_wdata),
        .o_wlast      (out_wlast),
        .o_retire     (w_retire),
        .o_idle       (w_fsm_idle)
    );

endmodule
`default_nettype wire

// File: tb/tb_line_wr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_wr_buffer
// Description : Directed self-checking bench for line_wr_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_wr_buffer;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         wr_req;
    logic [31:0]  wr_addr;
    logic [255:0] wr_data;
    logic         wr_rdy;
    logic [31:0]  rd_chk_addr;
    logic         rd_conflict;
    logic         empty;
    logic         out_awvalid;
    logic [31:0]  out_awaddr;
    logic         out_awready;
    logic         out_wvalid;
    logic [31:0]  out_wdata;
    logic         out_wlast;
    logic         out_wready;
    logic         out_bvalid;

    int n_checks = 0;
    int n_fail   = 0;

    line_wr_buffer #(
        .DEPTH      (2),
        .LINE_WORDS (8),
        .ADDR_W     (32)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_rdy      (wr_rdy),
        .rd_chk_addr (rd_chk_addr),
        .rd_conflict (rd_conflict),
        .empty       (empty),
        .out_awvalid (out_awvalid),
        .out_awaddr  (out_awaddr),
        .out_awready (out_awready),
        .out_wvalid  (out_wvalid),
        .out_wdata   (out_wdata),
        .out_wlast   (out_wlast),
        .out_wready  (out_wready),
        .out_bvalid  (out_bvalid)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Word w of a line built from base holds base + w
    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = base + 32'(w);
        return l;
    endfunction

    // Drain one line: expect its address, 8 ordered beats, then complete it
    task automatic drain_line(input logic [31:0] exp_addr, input logic [31:0] wbase, input bit toggle);
        int guard;
        int beats;
        bit ph;
        out_awready = 1'b1;
        out_wready  = 1'b1;
        out_bvalid  = 1'b0;
        #1;
        guard = 0;
        while (!out_awvalid && guard < 30) begin
            tick();
            guard++;
        end
        check_eq("aw_seen", out_awvalid, 1);
        check_eq("awaddr", out_awaddr, exp_addr);
        tick();
        beats = 0;
        guard = 0;
        ph    = 1'b1;
        while (beats < 8 && guard < 40) begin
            out_wready = toggle ? ph : 1'b1;
            #1;
            check_eq("wvalid", out_wvalid, 1);
            check_eq("wdata", out_wdata, wbase + 32'(beats));
            check_eq("wlast", out_wlast, (beats == 7));
            if (out_wready) beats++;
            ph = !ph;
            guard++;
            tick();
        end
        out_wready = 1'b0;
        #1;
        check_eq("resp_wvalid", out_wvalid, 0);
        check_eq("beat_count", beats, 8);
        out_bvalid = 1'b1;
        tick();
        out_bvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cyc;
        int  guard;
        bit  seen;

        aresetn     = 1'b0;
        wr_req      = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        rd_chk_addr = '0;
        out_awready = 1'b0;
        out_wready  = 1'b0;
        out_bvalid  = 1'b0;
        #2;
        // Reset values
        check_eq("rst_wr_rdy", wr_rdy, 1);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_conflict", rd_conflict, 0);
        check_eq("rst_awvalid", out_awvalid, 0);
        check_eq("rst_wvalid", out_wvalid, 0);
        check_eq("rst_wlast", out_wlast, 0);
        check_eq("rst_awaddr", out_awaddr, 0);
        check_eq("rst_wdata", out_wdata, 0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();

        // Single line, zero-wait downstream
        out_awready = 1'b1;
        out_wready  = 1'b1;
        out_bvalid  = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 32'h1C00_0020;
        wr_data = mk_line(32'h0);
        #1;
        check_eq("t1_rdy", wr_rdy, 1);
        tick();
        wr_req = 1'b0;
        cyc = 0;
        check_eq("t1_busy", empty, 0);
        check_eq("t1_idle_aw", out_awvalid, 0);
        tick(); cyc++;
        check_eq("t1_awvalid", out_awvalid, 1);
        check_eq("t1_awaddr", out_awaddr, 32'h1C00_0020);
        tick(); cyc++;
        for (int b = 0; b < 8; b++) begin
            check_eq("t1_wvalid", out_wvalid, 1);
            check_eq("t1_wdata", out_wdata, 32'(b));
            check_eq("t1_wlast", out_wlast, (b == 7));
            tick(); cyc++;
        end
        check_eq("t1_resp_wvalid", out_wvalid, 0);
        check_eq("t1_empty_c10", empty, 0);
        tick(); cyc++;
        check_eq("t1_empty_c11", empty, 1);

        // Fill with address stalled, plus conflict detection
        out_awready = 1'b0;
        out_bvalid  = 1'b0;
        wr_req  = 1'b1;
        wr_addr = 32'h0000_1000; wr_data = mk_line(32'h1000);
        #1;
        check_eq("fill_rdy0", wr_rdy, 1);
        tick();
        wr_addr = 32'h0000_2000; wr_data = mk_line(32'h2000);
        check_eq("fill_rdy1", wr_rdy, 1);
        tick();
        wr_addr = 32'h0000_3000; wr_data = mk_line(32'h3000);
        check_eq("fill_full", wr_rdy, 0);
        rd_chk_addr = 32'h0000_101C; #1;
        check_eq("cfl_hit", rd_conflict, 1);
        rd_chk_addr = 32'h0000_1020; #1;
        check_eq("cfl_miss", rd_conflict, 0);
        rd_chk_addr = 32'h0000_2004; #1;
        check_eq("cfl_hit2", rd_conflict, 1);
        tick();
        check_eq("fill_still_full", wr_rdy, 0);
        check_eq("aw_hold_valid", out_awvalid, 1);
        check_eq("aw_hold_addr", out_awaddr, 32'h0000_1000);
        rd_chk_addr = 32'h0000_101C;
        drain_line(32'h0000_1000, 32'h1000, 1'b0);
        #1;
        check_eq("cfl_after_b", rd_conflict, 0);
        check_eq("fill_rdy_after_b", wr_rdy, 1);
        tick();
        check_eq("fill_third_taken", wr_rdy, 0);
        wr_req = 1'b0;
        drain_line(32'h0000_2000, 32'h2000, 1'b0);
        drain_line(32'h0000_3000, 32'h3000, 1'b0);
        check_eq("fill_empty", empty, 1);

        // Ordering with a repeated line; B drained under wready backpressure
        wr_req  = 1'b1;
        wr_addr = 32'h0000_0100; wr_data = mk_line(32'h0100);
        tick();
        wr_addr = 32'h0000_0200; wr_data = mk_line(32'h0200);
        tick();
        wr_req = 1'b0;
        drain_line(32'h0000_0100, 32'h0100, 1'b0);
        wr_req  = 1'b1;
        wr_addr = 32'h0000_0100; wr_data = mk_line(32'hA100);
        check_eq("ord_rdy", wr_rdy, 1);
        tick();
        wr_req = 1'b0;
        drain_line(32'h0000_0200, 32'h0200, 1'b1);
        drain_line(32'h0000_0100, 32'hA100, 1'b0);
        check_eq("ord_empty", empty, 1);

        // Reset during beat 3
        out_awready = 1'b1;
        out_wready  = 1'b1;
        out_bvalid  = 1'b0;
        wr_req  = 1'b1;
        wr_addr = 32'h0000_4000; wr_data = mk_line(32'h4000);
        tick();
        wr_req = 1'b0;
        guard = 0;
        while (!(out_wvalid && out_wdata == 32'h4003) && guard < 20) begin
            tick();
            guard++;
        end
        check_eq("rst_at_beat3", out_wdata, 32'h4003);
        aresetn = 1'b0;
        #1;
        check_eq("mid_rst_wvalid", out_wvalid, 0);
        check_eq("mid_rst_empty", empty, 1);
        check_eq("mid_rst_wr_rdy", wr_rdy, 1);
        check_eq("mid_rst_wdata", out_wdata, 0);
        tick();
        tick();
        aresetn    = 1'b1;
        out_bvalid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_wvalid || out_awvalid) seen = 1'b1;
        end
        check_eq("post_rst_quiet", seen, 0);
        check_eq("post_rst_empty", empty, 1);

        // Offset bits of the enqueue address are dropped
        wr_req  = 1'b1;
        wr_addr = 32'h0000_5007; wr_data = mk_line(32'h5000);
        tick();
        wr_req = 1'b0;
        drain_line(32'h0000_5000, 32'h5000, 1'b0);
        check_eq("final_empty", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_wr_buffer.md
Name: line_wr_buffer

Overview:
- Dirty-line write-back buffer between the DCache write port (`dcache_wr_req` / `dcache_wr_addr` / `dcache_wr_data`) and the cache-to-AXI bridge write channel.
- Accepts whole 256-bit lines in one cycle so the DCache can refill without waiting. Drains lines in FIFO order as an address phase, 8 word beats and a completion response.
- Flags read addresses that hit a buffered line, so a refill never reads stale memory.

Parameters:
- DEPTH, 2, number of line entries; power of two, 2..8.
- LINE_WORDS, 8, 32-bit words per line; fixed 8 for the 256-bit line.
- ADDR_W, 32, address width.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- wr_req  in  1  DCache offers a victim line
- wr_addr  in  32  line address; bits [4:0] ignored and stored as zero
- wr_data  in  256  line data, word 0 in bits [31:0]
- wr_rdy  out  1  buffer can accept this cycle
- rd_chk_addr  in  32  address of the pending DCache refill
- rd_conflict  out  1  rd_chk_addr[31:5] matches a valid entry
- empty  out  1  no valid entries and drain FSM in IDLE
- out_awvalid  out  1  line address valid
- out_awaddr  out  32  line base address of the head entry
- out_awready  in  1  downstream accepts the address
- out_wvalid  out  1  data beat valid
- out_wdata  out  32  current word
- out_wlast  out  1  beat 7
- out_wready  in  1  downstream accepts the beat
- out_bvalid  in  1  line write completed

Behaviour:
- Reset (async assert, sync release): all entries invalid, both pointers 0, FSM in IDLE, beat counter 0. Output reset values:
  - wr_rdy=1, empty=1, rd_conflict=0
  - out_awvalid=0, out_wvalid=0, out_wlast=0
  - out_awaddr=0, out_wdata=0
- Reset mid-drain discards all entries; downstream is reset together with this block.
- Storage: DEPTH entries of {valid, addr[31:5], data[255:0]}. Write and read pointers each have log2(DEPTH)+1 bits.
  - full when the pointers differ only in the MSB.
  - wr_rdy = !full.
- Enqueue: on wr_req && wr_rdy, the entry at the write pointer is loaded with valid=1 and the write pointer increments.
  - wr_req while full is ignored; the DCache must hold the request.
  - No merging: a repeat write of the same line takes a new entry, so order is preserved.
- Drain FSM, operating on the head entry:
  - IDLE: a head entry is valid → ADDR next cycle, out_awvalid=1.
  - ADDR: out_awaddr={addr,5'b0}. On out_awready → DATA, beat=0.
  - DATA: out_wvalid=1, out_wdata=word[beat], out_wlast=(beat==7). Beat increments on each out_wready; out_wready on beat 7 → RESP.
  - RESP: wait for out_bvalid; then clear the head entry's valid, increment the read pointer, → IDLE.
  - Minimum per line: 1 (IDLE) + 1 (ADDR) + 8 (DATA) + 1 (RESP) = 11 cycles with zero-wait downstream.
  - out_awvalid and out_wvalid, once asserted, stay high with stable payload until accepted.
- The entry being drained stays valid until out_bvalid. It continues to drive rd_conflict and to count toward full.
- Simultaneous enqueue and retire in the same cycle are both performed; full deasserts the following cycle.
- rd_conflict is combinational over all valid entries.
  - Enqueue is not forwarded into rd_conflict in the same cycle; the DCache never refills the victim's own line in the enqueue cycle.
- empty = (no valid entries) && IDLE; it is the fence/uncached-ordering condition.
- out_bvalid outside RESP is ignored.

Decomposition:
- Shared package `cache_pkg`:
  - constants LINE_WORDS=8, LINE_BITS=256, OFFSET_W=5
  - `line_addr_t` = [31:5]
  - drain-state enum {IDLE, ADDR, DATA, RESP}
- One natural sub-module, `line_wr_drain_fsm`: the state, beat counter and beat mux. The top module keeps storage, pointers and the conflict compare.

Test Plan:
- Single line: enqueue addr 0x1C000020, words 0x0..0x7, zero-wait downstream → out_awaddr=0x1C000020. Beats 0..7 on 8 consecutive cycles, wlast only on beat 7. After bvalid: empty=1, 11 cycles after enqueue.
- Fill: three back-to-back wr_req with out_awready=0 → first two accepted, wr_rdy=0 on the third. Third accepted the cycle after the first line's bvalid.
- Conflict: line 0x00001000 buffered, rd_chk_addr=0x0000101C → rd_conflict=1. rd_chk_addr=0x00001020 → 0. After bvalid for 0x1000 → 0.
- Backpressure: out_wready toggles 1,0 every cycle → each word is held stable while unaccepted, no word is skipped, exactly 8 accepted beats.
- Order: enqueue A=0x100 then B=0x200, then A again → drained in order 0x100, 0x200, 0x100.
- Reset: assert aresetn=0 on beat 3 → the same cycle, out_wvalid=0, empty=1, wr_rdy=1. After release, no further beats until a new wr_req.
